hazard_stall_ctrl: RTL and testbench

- Pipeline hazard/stall controller for the 5-stage MIPS core; sits beside the ID stage.
- Detects load-use hazards (ID vs EX) and multiply/divide-unit busy hazards.
- Drives PC/IF-ID load enables, the ID control-mux select that injects a NOP bubble into the EX control path, and branch-redirect gating.
- Owns the mult/div latency counter, which runs in the background.

---
 rtl/hazard_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use / mult-div hazard and stall controller for the 5-stage MIPS core.
// Optional macro HAZARD_PERF_CNT_EN adds lu/md stall-cycle performance counters.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY      = 4,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_md_start,
  input  logic       id_md_read,
  input  logic       branch_taken,
  output logic       pc_le,
  output logic       ifid_le,
  output logic       cu_nop_sel,
  output logic       pc_redirect,
  output logic       md_busy,
  output logic       stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] lu_stall_cycles,
  output logic [15:0] md_stall_cycles
`endif
);

  // state    | meaning
  // RUN      | normal issue, hazards checked combinationally
  // LD_STALL | extra load-use bubbles, hazard inputs ignored
  // MD_STALL | waiting for mult/div unit to drain
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LD  = 2'd1;
  localparam logic [1:0] S_MD  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] r_ld_cnt;
  logic [3:0] r_md_cnt;

  logic [1:0] w_next_state;
  logic [1:0] w_next_ld_cnt;
  logic [3:0] w_next_md_cnt;
  logic       w_lu_hz;
  logic       w_md_hz;
  logic       w_md_busy;
  logic       w_stall;
  logic       w_md_accept;
  logic       w_lu_cause;
  logic       w_md_cause;

  always_comb begin
    w_lu_hz = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    w_md_busy     = (r_md_cnt != 4'd0);
    w_md_hz       = w_md_busy && (id_md_read || id_md_start);
    w_next_state  = r_state;
    w_next_ld_cnt = r_ld_cnt;
    w_stall       = 1'b0;
    w_lu_cause    = 1'b0;
    w_md_cause    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_stall    = w_lu_hz || w_md_hz;
        w_lu_cause = w_lu_hz;
        w_md_cause = w_md_hz && !w_lu_hz;
        if (w_lu_hz) begin
          if (LOAD_USE_STALLS > 1) begin
            w_next_state  = S_LD;
            w_next_ld_cnt = 2'(LOAD_USE_STALLS - 1);
          end
        end else if (w_md_hz) begin
          w_next_state = S_MD;
        end
      end
      S_LD: begin
        w_stall       = 1'b1;
        w_lu_cause    = 1'b1;
        w_next_ld_cnt = r_ld_cnt - 2'd1;
        if (r_ld_cnt <= 2'd1) w_next_state = S_RUN;
      end
      S_MD: begin
        w_stall    = w_md_busy;
        w_md_cause = w_md_busy;
        if (!w_md_busy) w_next_state = S_RUN;
      end
      default: w_next_state = S_RUN;
    endcase

    w_md_accept = id_md_start && !w_stall;
    if (w_md_accept)    w_next_md_cnt = 4'(MD_LATENCY);
    else if (w_md_busy) w_next_md_cnt = r_md_cnt - 4'd1;
    else                w_next_md_cnt = 4'd0;
  end

  // Reset forces the idle output pattern regardless of inputs.
  assign stall       = !reset && w_stall;
  assign pc_le       = !stall;
  assign ifid_le     = !stall;
  assign cu_nop_sel  = stall;
  assign pc_redirect = !reset && branch_taken && !w_stall;
  assign md_busy     = !reset && w_md_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_ld_cnt <= 2'd0;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_next_state;
      r_ld_cnt <= w_next_ld_cnt;
      r_md_cnt <= w_next_md_cnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_lu_perf;
  logic [15:0] r_md_perf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lu_perf <= 16'd0;
      r_md_perf <= 16'd0;
    end else begin
      if (w_lu_cause && (r_lu_perf != 16'hFFFF)) r_lu_perf <= r_lu_perf + 16'd1;
      if (w_md_cause && (r_md_perf != 16'hFFFF)) r_md_perf <= r_md_perf + 16'd1;
    end
  end

  assign lu_stall_cycles = r_lu_perf;
  assign md_stall_cycles = r_md_perf;
`else
  logic w_unused_cause;
  assign w_unused_cause = w_lu_cause ^ w_md_cause;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: default instance (1 load-use bubble) and a 3-bubble instance share inputs.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       id_md_start, id_md_read, branch_taken;

  logic pc_le, ifid_le, cu_nop_sel, pc_redirect, md_busy, stall;
  logic pc_le3, ifid_le3, cu_nop_sel3, pc_redirect3, md_busy3, stall3;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lu_cyc, md_cyc, lu_cyc3, md_cyc3;
`endif

  int n_err = 0;
  int n_checks = 0;

  hazard_stall_ctrl u_dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_md_start(id_md_start), .id_md_read(id_md_read),
    .branch_taken(branch_taken), .pc_le(pc_le), .ifid_le(ifid_le),
    .cu_nop_sel(cu_nop_sel), .pc_redirect(pc_redirect), .md_busy(md_busy),
    .stall(stall)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cycles(lu_cyc), .md_stall_cycles(md_cyc)
`endif
  );

  hazard_stall_ctrl #(.MD_LATENCY(4), .LOAD_USE_STALLS(3)) u_dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_md_start(id_md_start), .id_md_read(id_md_read),
    .branch_taken(branch_taken), .pc_le(pc_le3), .ifid_le(ifid_le3),
    .cu_nop_sel(cu_nop_sel3), .pc_redirect(pc_redirect3), .md_busy(md_busy3),
    .stall(stall3)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cycles(lu_cyc3), .md_stall_cycles(md_cyc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    id_md_start = 1'b0; id_md_read = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_lu_rs(input logic [4:0] r);
    ex_mem_read = 1'b1; ex_rd = r; id_uses_rs = 1'b1; id_rs = r;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    // Hazards and branch present while in reset: outputs must stay idle.
    set_lu_rs(5'd8);
    branch_taken = 1'b1;
    id_md_start = 1'b1;
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_pc_le", pc_le, 1'b1);
    chk("rst_ifid_le", ifid_le, 1'b1);
    chk("rst_nop", cu_nop_sel, 1'b0);
    chk("rst_redirect", pc_redirect, 1'b0);
    chk("rst_md_busy", md_busy, 1'b0);
    tick();
    reset = 1'b0;
    clear_in();
    #1;
    chk("post_rst_md_busy", md_busy, 1'b0);
    chk("post_rst_stall3", stall3, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("post_rst_lu_cyc", lu_cyc, 16'd0);
`endif
    tick();

    // Single-cycle load-use on rs.
    set_lu_rs(5'd8);
    #1;
    chk("lu_stall", stall, 1'b1);
    chk("lu_pc_le", pc_le, 1'b0);
    chk("lu_ifid_le", ifid_le, 1'b0);
    chk("lu_nop", cu_nop_sel, 1'b1);
    chk("lu3_stall_c0", stall3, 1'b1);
    tick();
    ex_mem_read = 1'b0;
    #1;
    chk("lu_stall_c1", stall, 1'b0);
    chk("lu_pc_le_c1", pc_le, 1'b1);
    chk("lu3_stall_c1", stall3, 1'b1);
    tick();
    #1;
    chk("lu3_stall_c2", stall3, 1'b1);
    chk("lu_stall_c2", stall, 1'b0);
    tick();
    #1;
    chk("lu3_stall_c3", stall3, 1'b0);
    chk("lu3_pc_le_c3", pc_le3, 1'b1);
    clear_in();
    tick();

    // rt path and uses-flag qualification, register 0 exemption (combinational, same cycle).
    ex_mem_read = 1'b1; ex_rd = 5'd17; id_rt = 5'd17; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
    #1;
    chk("lu_rt_stall", stall, 1'b1);
    id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", stall, 1'b0);
    ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    chk("r0_exempt", stall, 1'b0);
    chk("r0_exempt3", stall3, 1'b0);
    ex_rd = 5'd5; id_rs = 5'd5; ex_mem_read = 1'b0;
    #1;
    chk("no_load_no_stall", stall, 1'b0);
    clear_in();
    tick();

    // Branch during load-use stall, then re-resolved.
    set_lu_rs(5'd9);
    branch_taken = 1'b1;
    #1;
    chk("br_stall_redirect", pc_redirect, 1'b0);
    tick();
    ex_mem_read = 1'b0;
    #1;
    chk("br_retry_redirect", pc_redirect, 1'b1);
    chk("br3_ld_redirect", pc_redirect3, 1'b0);
    branch_taken = 1'b0;
    tick();
    tick();
    #1;
    chk("br3_back_run", stall3, 1'b0);
    clear_in();
    tick();

    // mult accepted, then mfhi stalls until the unit drains.
    id_md_start = 1'b1;
    #1;
    chk("md_start_nostall", stall, 1'b0);
    tick();
    id_md_start = 1'b0;
    #1;
    chk("md_busy_T", md_busy, 1'b1);
    chk("md_nostall_T", stall, 1'b0);
    tick();
    id_md_read = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("mfhi_stall_T%0d", i), stall, 1'b1);
      chk($sformatf("mfhi_nop_T%0d", i), cu_nop_sel, 1'b1);
      tick();
    end
    #1;
    chk("mfhi_release_stall", stall, 1'b0);
    chk("mfhi_release_busy", md_busy, 1'b0);
    chk("mfhi_release_pc_le", pc_le, 1'b1);
    chk("mfhi3_release_stall", stall3, 1'b0);

    // Back-to-back mult: the second waits and is accepted when the unit goes idle.
    id_md_read = 1'b0;
    id_md_start = 1'b1;
    #1;
    chk("mul1_accept", stall, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mul2_wait_%0d", i), stall, 1'b1);
      tick();
    end
    #1;
    chk("mul2_accept_stall", stall, 1'b0);
    chk("mul2_accept_busy", md_busy, 1'b0);
    tick();
    id_md_start = 1'b0;
    #1;
    chk("mul2_running", md_busy, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("mul2_drained", md_busy, 1'b0);

    // Start coinciding with load-use is not accepted.
    set_lu_rs(5'd12);
    id_md_start = 1'b1;
    #1;
    chk("lu_md_stall", stall, 1'b1);
    tick();
    clear_in();
    #1;
    chk("lu_md_not_accepted", md_busy, 1'b0);
    tick();
    tick();
    tick();

    // Reset while in MD_STALL abandons the operation.
    id_md_start = 1'b1;
    tick();
    id_md_start = 1'b0;
    tick();
    id_md_read = 1'b1;
    #1;
    chk("rmd_stall_T1", stall, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("rmd_reset_stall", stall, 1'b0);
    chk("rmd_reset_pc_le", pc_le, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    chk("rmd_after_busy", md_busy, 1'b0);
    chk("rmd_after_stall", stall, 1'b0);
    chk("rmd_after_pc_le", pc_le, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
    chk("rmd_after_md_cyc", md_cyc, 16'd0);
`endif
    clear_in();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
